gray_sync_decoder: RTL

- Downstream consumer of the Gray-coded up-counter output.
- Re-times the Gray word through a synchronizer chain into the local clk domain, then converts it to binary.
- Checks that every observed change is exactly +1 (mod 2^N) and emits a valid pulse, a wrap pulse, and error reporting with a saturating error counter.
- Sits between the Gray counter (or any Gray-coded pointer source) and binary consumers such as occupancy or rate logic.

---
 rtl/gray_pkg.sv | 26 ++
 rtl/sync_chain.sv | 30 +++
 rtl/gray_sync_decoder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path.
// Holds the decoder state encoding and the Gray-to-binary conversion.
package gray_pkg;

  typedef enum logic [1:0] {
    INIT,
    LOCKED,
    RESYNC
  } state_t;

  localparam int MAX_W = 32;
  localparam logic [MAX_W-1:0] ONES = '1;

  // Callers zero-extend to MAX_W and truncate back to their width.
  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a Gray-coded bus.
// Kept as its own module so CDC constraints can target it directly.
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        s[k] <= '0;
      end
    end else begin
      s[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        s[k] <= s[k-1];
      end
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronizes a Gray count, converts it to binary and checks that
// every observed change is a +1 step, counting violations.
module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         gray_in,
  input  logic                 clr_err,
  output logic [N-1:0]         bin_out,
  output logic                 bin_valid,
  output logic                 wrap,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 locked
);

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [N-1:0] ALL_ONES = ONES[N-1:0];
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t state, state_d;

  logic [FW-1:0]        fill, fill_d;
  logic [N-1:0]         gs, gs_q, nb, bin_d;
  logic [ERR_CNT_W-1:0] cnt_d;
  logic                 valid_d, wrap_d, err_d, locked_d;
  logic                 changed, step_ok;

  sync_chain #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gray_in),
    .q   (gs)
  );

  assign nb      = N'(gray2bin(MAX_W'(gs)));
  assign changed = (gs != gs_q);
  assign step_ok = (nb == N'(bin_out + 1));

  always_comb begin
    state_d  = state;
    fill_d   = fill;
    bin_d    = bin_out;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    locked_d = locked;
    cnt_d    = err_cnt;
    unique case (state)
      INIT: begin
        if (fill == FW'(SYNC_STAGES)) begin
          bin_d    = nb;
          locked_d = 1'b1;
          state_d  = LOCKED;
        end else begin
          fill_d = fill + FW'(1);
        end
      end
      LOCKED: begin
        if (changed) begin
          bin_d   = nb;
          valid_d = 1'b1;
          if (step_ok) begin
            wrap_d = (bin_out == ALL_ONES);
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = RESYNC;
            if (err_cnt != ERR_MAX) begin
              cnt_d = err_cnt + ERR_CNT_W'(1);
            end
          end
        end
      end
      RESYNC: begin
        if (changed) begin
          bin_d    = nb;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
      end
      default: state_d = INIT;
    endcase
    // Clear takes priority over a same-cycle error increment.
    if (clr_err) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      fill      <= '0;
      gs_q      <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      fill      <= fill_d;
      gs_q      <= gs;
      bin_out   <= bin_d;
      bin_valid <= valid_d;
      wrap      <= wrap_d;
      step_err  <= err_d;
      err_cnt   <= cnt_d;
      locked    <= locked_d;
    end
  end

endmodule
